popcount_arb: RTL and testbench
===============================

# popcount_arb

Shares one popcount datapath between `N_REQ` independent requesters with round-robin arbitration and a two-stage registered pipeline. Returns each result on a single response channel tagged with the requester index. Sits between several CXU-L0-style popcount clients, for example per-hart issue ports, and a single compressor-tree or adder-tree popcount instance. This saves area when popcount is infrequent per client.

## Interface
- `N_REQ`, 4: number of requesters; legal 2..8.
- `DATA_W`, 32: operand and result width; legal 32 or 64.
- `ADDER_TREE`, 0: 0 selects the 6:3-compressor datapath; nonzero selects the adder-tree datapath.
- `ID_W`, $clog2(N_REQ): width of the response tag (derived; do not override).

Ports:
- `clk` input 1: the only clock; all state is on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input N_REQ: requester i presents an operand.
- `req_ready` output N_REQ: requester i's operand is accepted this cycle.
- `req_data` input N_REQ×DATA_W: per-requester operand, packed, with requester i at `[i]`.
- `resp_valid` output 1: a result is presented.
- `resp_ready` input 1: the consumer accepts the result.
- `resp_data` output DATA_W: population count of the operand, zero-extended.
- `resp_id` output ID_W: index of the requester that issued the operand.

## Operation
- **Arbitration.** A round-robin pointer `ptr` (ID_W bits) names the highest-priority requester. The grant goes to the first i with `req_valid[i]`, scanning `ptr, ptr+1, …` modulo N_REQ.
- **Handshake.** `req_ready[i]` = grant[i] AND `s1_accept`. At most one bit is set, and never for a requester with valid low. A transfer occurs when `req_valid[i] && req_ready[i]`.
- **Pointer update.** On a transfer from requester i, `ptr` becomes `(i+1) mod N_REQ`. Without a transfer, `ptr` holds.
- **Stage 1 (S1).** Registers `{valid, id, operand}`. The shared popcount datapath is driven from the S1 operand register only, never directly from `req_data`.
- **Stage 2 (S2).** Registers `{valid, id, count}`. S2 drives `resp_valid`, `resp_id` and `resp_data`.
- **Advance rules:**
  - `s2_accept` = !S2.valid OR `resp_ready`.
  - S2 loads from S1 when `s2_accept`.
  - `s1_accept` = !S1.valid OR `s2_accept`.
  - S1 loads the granted request when `s1_accept`.
  - If a stage can accept but no transfer feeds it, its valid clears.
- **Count width.** The count is at most DATA_W. It is computed in a 7-bit field and zero-extended to DATA_W.
- **Requester obligations.** Once `req_valid` is asserted, requesters hold it and `req_data` stable until the transfer. The arbiter does not rely on this: the grant is recomputed every cycle.
- **Consumer ordering.** Responses leave in acceptance order. No reordering and no drops.

## Timing
- **Reset values.** While `rst` is high, and asynchronously on its assertion:
  - S1.valid = S2.valid = 0, `ptr` = 0.
  - `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0.
  - `req_ready` = 0, forced low for the whole time `rst` is high.
- **Reset mid-operation.** Contents of S1 and S2 are discarded, with no response for them. The first cycle after deassertion behaves as a fresh start with `ptr` = 0.
- **Latency.** A transfer in cycle t gives `resp_valid` high in cycle t+2, provided S2 was free to advance.
- **Throughput.** One result per cycle when `resp_ready` is held high, for example back-to-back from a single requester.
- **Backpressure.** While `resp_valid && !resp_ready`:
  - `resp_data` and `resp_id` hold stable.
  - S1 holds if it is valid.
  - With both stages full, all `req_ready` = 0.
  - When `resp_ready` rises, both stages shift in the same cycle and one new request is accepted.
- **Pipeline occupancy.** At most 2 results are in flight; there is no other buffering.
- **Same-cycle events.** A transfer and a response handshake in the same cycle are legal and both take effect.
- **Pointer wrap.** A grant to requester N_REQ-1 sets `ptr` to 0.

## Test plan
- **Single request.** Requester 2 sends `32'hF0F0_0001`, `resp_ready`=1 → `resp_valid` at t+2 with `resp_data`=9, `resp_id`=2, then low the next cycle.
- **Round-robin fairness.** All 4 requesters hold valid continuously, `resp_ready`=1 → one grant per cycle in order 0,1,2,3,0,…; `resp_id` follows the same sequence 2 cycles later.
- **Backpressure.**
  - Setup: two requests accepted, then `resp_ready`=0 for 5 cycles.
  - During the stall: `resp_valid`=1 and `resp_data`/`resp_id` stable; all `req_ready`=0 once both stages are full; no request is lost.
  - On release: results arrive in acceptance order.
- **Width extremes.** With DATA_W=64, operands `64'hFFFF_FFFF_FFFF_FFFF` → 64 and `64'h0` → 0; upper result bits are 0. With DATA_W=32, all-ones → 32. Repeat both with ADDER_TREE=1.
- **Reset mid-flight.** Assert `rst` asynchronously with S1 and S2 full → `resp_valid` and `req_ready` drop immediately. After deassertion, no stale response appears, and with all requesters valid the first grant goes to requester 0.
- **Randomized against a model.** Random valid/ready/data for 10k cycles versus a scoreboard model → every accepted operand yields exactly one correct count with the correct id, in order. No requester that holds valid waits more than N_REQ grant opportunities.

Source files
------------

// File: rtl/popcount_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | popcount_arb: round-robin arbiter sharing one popcount datapath    |
// | behind a two-stage valid/ready pipeline.       Revision: 1.0       |
// +--------------------------------------------------------------------+
module popcount_arb #(
   parameter int N_REQ      = 4,
   parameter int DATA_W     = 32,
   parameter int ADDER_TREE = 0,
   parameter int ID_W       = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [DATA_W-1:0]         resp_data,
   output logic [ID_W-1:0]           resp_id
);

   localparam int c_CNT_W = 7;

   logic [ID_W-1:0]    r_ptr;
   logic               r_s1_valid;
   logic [ID_W-1:0]    r_s1_id;
   logic [DATA_W-1:0]  r_s1_data;
   logic               r_s2_valid;
   logic [ID_W-1:0]    r_s2_id;
   logic [DATA_W-1:0]  r_s2_cnt;

   logic               w_s1_accept;
   logic               w_s2_accept;
   logic [N_REQ-1:0]   w_grant;
   logic [ID_W-1:0]    w_gnt_id;
   logic               w_gnt_any;
   logic [ID_W-1:0]    w_idx;
   logic [c_CNT_W-1:0] w_cnt;

   // 6:3 compressor built from two full adders; weight-2 carries summed separately
   function automatic logic [2:0] f_c63(input logic [5:0] b);
      logic       s_a, c_a, s_b, c_b;
      logic [1:0] twos;
      s_a  = b[0] ^ b[1] ^ b[2];
      c_a  = (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
      s_b  = b[3] ^ b[4] ^ b[5];
      c_b  = (b[3] & b[4]) | (b[3] & b[5]) | (b[4] & b[5]);
      twos = {1'b0, c_a} + {1'b0, c_b} + {1'b0, s_a & s_b};
      return {twos, s_a ^ s_b};
   endfunction

   assign w_s2_accept = !r_s2_valid || resp_ready;
   assign w_s1_accept = !r_s1_valid || w_s2_accept;

   always_comb begin
      w_grant   = '0;
      w_gnt_id  = '0;
      w_gnt_any = 1'b0;
      w_idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
         if (!w_gnt_any && req_valid[w_idx]) begin
            w_gnt_any      = 1'b1;
            w_grant[w_idx] = 1'b1;
            w_gnt_id       = w_idx;
         end
      end
   end

   // ready is held low for the whole reset interval, not just until the next edge
   assign req_ready = rst ? '0 : (w_grant & {N_REQ{w_s1_accept}});

   generate
      if (ADDER_TREE != 0) begin : g_adder_tree
         logic [c_CNT_W-1:0] w_sum [DATA_W];
         always_comb begin
            for (int i = 0; i < DATA_W; i++) begin
               w_sum[i] = {{(c_CNT_W-1){1'b0}}, r_s1_data[i]};
            end
            for (int s = 1; s < DATA_W; s = s * 2) begin
               for (int i = 0; i + s < DATA_W; i = i + 2 * s) begin
                  w_sum[i] = w_sum[i] + w_sum[i+s];
               end
            end
            w_cnt = w_sum[0];
         end
      end else begin : g_csa
         localparam int c_NGRP = (DATA_W + 5) / 6;
         logic [6*c_NGRP-1:0] w_pad;
         logic [c_CNT_W-1:0]  w_acc;
         assign w_pad = {{(6*c_NGRP-DATA_W){1'b0}}, r_s1_data};
         always_comb begin
            w_acc = '0;
            for (int g = 0; g < c_NGRP; g++) begin
               w_acc = w_acc + {{(c_CNT_W-3){1'b0}}, f_c63(w_pad[6*g +: 6])};
            end
            w_cnt = w_acc;
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_id    <= '0;
         r_s1_data  <= '0;
         r_s2_valid <= 1'b0;
         r_s2_id    <= '0;
         r_s2_cnt   <= '0;
      end else begin
         if (w_s1_accept) begin
            r_s1_valid <= w_gnt_any;
            if (w_gnt_any) begin
               r_s1_id   <= w_gnt_id;
               r_s1_data <= req_data[w_gnt_id*DATA_W +: DATA_W];
               r_ptr     <= (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
            end
         end
         if (w_s2_accept) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_id  <= r_s1_id;
               r_s2_cnt <= {{(DATA_W-c_CNT_W){1'b0}}, w_cnt};
            end
         end
      end
   end

   assign resp_valid = r_s2_valid;
   assign resp_data  = r_s2_cnt;
   assign resp_id    = r_s2_id;

endmodule
`default_nettype wire

// File: tb/tb_popcount_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_popcount_arb: directed and random checks of popcount_arb        |
// | against a transaction-level model.             Revision: 1.0       |
// +--------------------------------------------------------------------+
module tb_popcount_arb;
   localparam int N = 4;
   localparam int W = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_data = '0;
   logic            resp_valid;
   logic            resp_ready = 1'b0;
   logic [W-1:0]    resp_data;
   logic [1:0]      resp_id;

   logic [1:0]      wv = '0;
   logic [127:0]    wd64 = '0;
   logic [63:0]     wd32 = '0;
   logic            wrr = 1'b1;
   logic [1:0]      rdy_64c, rdy_64t, rdy_32t;
   logic            v_64c, v_64t, v_32t;
   logic [63:0]     d_64c, d_64t;
   logic [31:0]     d_32t;
   logic            id_64c, id_64t, id_32t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   popcount_arb #(.N_REQ(N), .DATA_W(W), .ADDER_TREE(0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_id(resp_id));

   popcount_arb #(.N_REQ(2), .DATA_W(64), .ADDER_TREE(0)) u_w64c (
      .clk(clk), .rst(rst), .req_valid(wv), .req_ready(rdy_64c),
      .req_data(wd64), .resp_valid(v_64c), .resp_ready(wrr),
      .resp_data(d_64c), .resp_id(id_64c));

   popcount_arb #(.N_REQ(2), .DATA_W(64), .ADDER_TREE(1)) u_w64t (
      .clk(clk), .rst(rst), .req_valid(wv), .req_ready(rdy_64t),
      .req_data(wd64), .resp_valid(v_64t), .resp_ready(wrr),
      .resp_data(d_64t), .resp_id(id_64t));

   popcount_arb #(.N_REQ(2), .DATA_W(32), .ADDER_TREE(1)) u_w32t (
      .clk(clk), .rst(rst), .req_valid(wv), .req_ready(rdy_32t),
      .req_data(wd32), .resp_valid(v_32t), .resp_ready(wrr),
      .resp_data(d_32t), .resp_id(id_32t));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_data();
      case ($urandom_range(0, 3))
         0:       return '1;
         1:       return '0;
         default: return W'($urandom);
      endcase
   endfunction

   // Transaction model: in-flight results in acceptance order, each visible two cycles after its transfer
   typedef struct {
      int t;
      int id;
      int cnt;
   } item_t;

   item_t        q[$];
   int           m_ptr = 0;
   int           waits[N];
   logic [N-1:0] xfer_seen = '0;

   always @(negedge clk) begin
      int           g;
      logic         acc;
      logic [N-1:0] exp_ready;
      logic         exp_rv;
      item_t        it;
      xfer_seen = req_valid & req_ready;
      if (rst) begin
         q.delete();
         m_ptr = 0;
         for (int i = 0; i < N; i++) waits[i] = 0;
         chk("rst_req_ready", req_ready, 0);
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_resp_data", resp_data, 0);
         chk("rst_resp_id", resp_id, 0);
      end else begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
         acc       = (q.size() < 2) || resp_ready;
         exp_ready = (g >= 0 && acc) ? N'(1 << g) : '0;
         chk("model_req_ready", req_ready, exp_ready);
         exp_rv = (q.size() > 0) && (cyc - q[0].t >= 2);
         chk("model_resp_valid", resp_valid, exp_rv);
         if (exp_rv) begin
            chk("model_resp_id", resp_id, q[0].id);
            chk("model_resp_data", resp_data, q[0].cnt);
            if (resp_ready) void'(q.pop_front());
         end
         for (int i = 0; i < N; i++) if (!req_valid[i]) waits[i] = 0;
         if (exp_ready != '0) begin
            it.t   = cyc;
            it.id  = g;
            it.cnt = $countones(req_data[g*W +: W]);
            q.push_back(it);
            m_ptr = (g + 1) % N;
            for (int i = 0; i < N; i++) begin
               if (i == g) waits[i] = 0;
               else if (req_valid[i]) begin
                  waits[i]++;
                  chk("fair_wait_bound", (waits[i] <= N - 1), 1'b1);
               end
            end
         end
      end
   end

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   logic [63:0] ops[16];

   initial begin
      // Single request from requester 2
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      req_valid = 4'b0100;
      req_data[2*W +: W] = 32'hF0F0_0001;
      resp_ready = 1'b1;
      #1 chk("single_ready", req_ready, 4'b0100);
      @(posedge clk);
      #1 req_valid = '0;
      chk("single_t1_rv", resp_valid, 0);
      @(posedge clk);
      #1 chk("single_t2_rv", resp_valid, 1);
      chk("single_t2_data", resp_data, 9);
      chk("single_t2_id", resp_id, 2);
      @(posedge clk);
      #1 chk("single_t3_rv", resp_valid, 0);

      // Round-robin with all requesters holding valid
      pulse_reset();
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'((1 << (i + 1)) - 1);
      req_valid = '1;
      for (int k = 0; k < 10; k++) begin
         logic [3:0] e;
         e = 4'(1 << (k % 4));
         #1 chk("rr_grant", req_ready, e);
         if (k >= 2) begin
            chk("rr_resp_id", resp_id, (k - 2) % 4);
            chk("rr_resp_data", resp_data, ((k - 2) % 4) + 1);
         end
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      repeat (3) @(posedge clk);

      // Backpressure: two accepted, five stalled cycles, then release
      #1 pulse_reset();
      resp_ready = 1'b0;
      req_data[0*W +: W] = 32'h0000_00FF;
      req_data[1*W +: W] = 32'h0000_0007;
      req_data[2*W +: W] = 32'hFFFF_FFFF;
      req_valid = 4'b0111;
      for (int k = 0; k < 11; k++) begin
         if (k == 7) resp_ready = 1'b1;
         #1;
         if (k == 0) chk("bp_grant0", req_ready, 4'b0001);
         if (k == 1) chk("bp_grant1", req_ready, 4'b0010);
         if (k >= 2 && k <= 6) begin
            chk("bp_stall_ready", req_ready, 0);
            chk("bp_stall_rv", resp_valid, 1);
            chk("bp_stall_id", resp_id, 0);
            chk("bp_stall_data", resp_data, 8);
         end
         if (k == 7) begin
            chk("bp_release_grant", req_ready, 4'b0100);
            chk("bp_release_id", resp_id, 0);
         end
         if (k == 8) begin
            chk("bp_order_id1", resp_id, 1);
            chk("bp_order_data1", resp_data, 3);
         end
         if (k == 9) begin
            chk("bp_order_id2", resp_id, 2);
            chk("bp_order_data2", resp_data, 32);
         end
         if (k == 10) chk("bp_drained", resp_valid, 0);
         @(posedge clk);
         #1;
         if (k == 0) req_valid[0] = 1'b0;
         if (k == 1) req_valid[1] = 1'b0;
         if (k == 7) req_valid[2] = 1'b0;
      end

      // Width extremes on the 64-bit and adder-tree instances
      ops[0] = '1;
      ops[1] = '0;
      ops[2] = 64'h8000_0000_0000_0001;
      ops[3] = 64'hFFFF_FFFF_0000_0000;
      for (int i = 4; i < 16; i++) ops[i] = {32'($urandom), 32'($urandom)};
      @(posedge clk);
      for (int k = 0; k < 18; k++) begin
         #1;
         wv = (k < 16) ? 2'b01 : 2'b00;
         if (k < 16) begin
            wd64[63:0] = ops[k];
            wd32[31:0] = ops[k][31:0];
         end
         #1;
         chk("w_ready_64c", rdy_64c, (k < 16) ? 2'b01 : 2'b00);
         chk("w_ready_64t", rdy_64t, (k < 16) ? 2'b01 : 2'b00);
         chk("w_ready_32t", rdy_32t, (k < 16) ? 2'b01 : 2'b00);
         if (k >= 2) begin
            chk("w64c_valid", v_64c, 1);
            chk("w64t_valid", v_64t, 1);
            chk("w32t_valid", v_32t, 1);
            chk("w64c_data", d_64c, $countones(ops[k-2]));
            chk("w64t_data", d_64t, $countones(ops[k-2]));
            chk("w32t_data", d_32t, $countones(ops[k-2][31:0]));
            chk("w64t_id", id_64t, 0);
         end
         if (k == 2) begin
            chk("w64c_all_ones", d_64c, 64);
            chk("w64t_all_ones", d_64t, 64);
            chk("w32t_all_ones", d_32t, 32);
         end
         if (k == 3) begin
            chk("w64c_zero", d_64c, 0);
            chk("w64t_zero", d_64t, 0);
         end
         @(posedge clk);
      end

      // Reset with both stages full
      #1 pulse_reset();
      for (int i = 0; i < N; i++) req_data[i*W +: W] = rnd_data();
      req_valid  = '1;
      resp_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 chk("mid_full_rv", resp_valid, 1);
      #1 rst = 1'b1;
      #1 chk("mid_async_rv", resp_valid, 0);
      chk("mid_async_ready", req_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      resp_ready = 1'b1;
      #1 chk("mid_first_grant", req_ready, 4'b0001);
      chk("mid_no_stale", resp_valid, 0);
      repeat (8) @(posedge clk);

      // Random traffic; requesters hold valid and data until their transfer
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (xfer_seen[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               if (req_valid[i]) req_data[i*W +: W] = rnd_data();
            end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               req_data[i*W +: W] = rnd_data();
            end
         end
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("final_drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
